fetch_buffered: RTL

Parametrised instruction-fetch front end with a decoupling queue between instruction memory and decode. Owns the program counter and issues one word-aligned read per cycle to a 1-cycle-latency synchronous instruction memory. Buffers returned words with their PC in a FIFO and presents them to decode over a valid/ready handshake. Supports a redirect that flushes the queue and squashes the in-flight read, and a hold that freezes new fetches.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buffered_if.sv | 36 +++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_buffered.sv | 96 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the buffered fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffered_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_buffered_if
// Purpose  : Redirect/hold control, instruction-memory port and decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_buffered_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int FQ_DEPTH   = 4
);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  fetch_hold;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [31:0]           out_instr;
  logic [CNT_W-1:0]      fq_count;

  modport master (
    input  redirect_valid, redirect_pc, fetch_hold, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_pc, out_instr, fq_count
  );

  modport slave (
    output redirect_valid, redirect_pc, fetch_hold, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_pc, out_instr, fq_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of {pc, instr} entries; flush beats push.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop frees the slot, so a push into a full queue is legal alongside it.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_buffered
// Purpose  : PC owner and issue logic feeding a fetch queue toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_buffered_if.master  bus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic             if_valid_q, if_valid_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             fifo_empty;
  logic             fifo_full_unused;
  logic             unused_pc_bits;
  logic             pop;
  logic             push;
  logic             issue;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  assign pop       = ~fifo_empty & bus.out_ready;
  // Slots already promised: queued words minus this cycle's pop plus the read in flight.
  assign occupancy = OCC_W'(count) - OCC_W'(pop) + OCC_W'(if_valid_q);
  assign issue     = ~rst & ~bus.redirect_valid & ~bus.fetch_hold
                   & (occupancy < OCC_W'(FQ_DEPTH));

  assign push       = if_valid_q & ~bus.redirect_valid;
  assign push_entry = '{pc: if_pc_q, instr: bus.imem_rdata};

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc_q[ADDR_WIDTH+1:2];
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.fq_count  = count;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      if_valid_d = 1'b0;
    end else if (issue) begin
      if_pc_d    = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count),
    .full      (fifo_full_unused),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire
